// File: rtl/ccm_pkg.sv
// Shared types and constants for the 3x3 colour-correction stage.
// Holds the coefficient bank layout, write addresses and the identity reset bank.
package ccm_pkg;

  localparam int unsigned CCM_MAX_WIDTH = 32;
  localparam int unsigned NUM_COEF      = 12;

  typedef logic signed [CCM_MAX_WIDTH-1:0] coef_t;
  typedef coef_t [NUM_COEF-1:0]            coef_bank_t;

  localparam logic [3:0] CCM_ADDR_M00   = 4'd0;
  localparam logic [3:0] CCM_ADDR_M01   = 4'd1;
  localparam logic [3:0] CCM_ADDR_M02   = 4'd2;
  localparam logic [3:0] CCM_ADDR_M10   = 4'd3;
  localparam logic [3:0] CCM_ADDR_M11   = 4'd4;
  localparam logic [3:0] CCM_ADDR_M12   = 4'd5;
  localparam logic [3:0] CCM_ADDR_M20   = 4'd6;
  localparam logic [3:0] CCM_ADDR_M21   = 4'd7;
  localparam logic [3:0] CCM_ADDR_M22   = 4'd8;
  localparam logic [3:0] CCM_ADDR_OFF_R = 4'd9;
  localparam logic [3:0] CCM_ADDR_OFF_G = 4'd10;
  localparam logic [3:0] CCM_ADDR_OFF_B = 4'd11;

  // Unity on the diagonal in Q(frac) format, everything else zero.
  function automatic coef_bank_t ccm_identity(int unsigned frac);
    coef_bank_t bank;
    bank = '0;
    bank[CCM_ADDR_M00] = coef_t'(32'd1 << frac);
    bank[CCM_ADDR_M11] = coef_t'(32'd1 << frac);
    bank[CCM_ADDR_M22] = coef_t'(32'd1 << frac);
    return bank;
  endfunction

endpackage

// File: rtl/ccm_channel.sv
// One output row of the colour matrix: multiply, sum, shift and saturate over three stages.
// CCM_ROUND_EN selects round-half-up instead of floor in the sum stage.
module ccm_channel #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m0_i,
  input  logic [WIDTH-1:0] m1_i,
  input  logic [WIDTH-1:0] m2_i,
  input  logic [WIDTH-1:0] off_i,
  output logic [WIDTH-1:0] out_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = 2 * WIDTH + 2;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef CCM_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(64'd1 << (FRAC - 1));
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic signed [PW-1:0]    p0_d, p1_d, p2_d, p0_q, p1_q, p2_q;
  logic signed [SW-1:0]    off_d, off_q, sum_d, sum_q, shr;
  logic        [WIDTH-1:0] out_d, out_q;

  always_comb begin
    p0_d  = PW'($signed(m0_i)) * PW'($signed(r_i));
    p1_d  = PW'($signed(m1_i)) * PW'($signed(g_i));
    p2_d  = PW'($signed(m2_i)) * PW'($signed(b_i));
    off_d = SW'($signed(off_i)) <<< FRAC;
    sum_d = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + off_q + RND;
    shr   = sum_q >>> FRAC;
    if (shr > SAT_MAX) begin
      out_d = SAT_MAX[WIDTH-1:0];
    end else if (shr < SAT_MIN) begin
      out_d = SAT_MIN[WIDTH-1:0];
    end else begin
      out_d = shr[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      off_q <= '0;
      sum_q <= '0;
      out_q <= '0;
    end else if (adv_i) begin
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      off_q <= off_d;
      sum_q <= sum_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/color_correct_stencil.sv
// Pipelined 3x3 colour-correction stage with a programmable coefficient bank.
// Define CCM_ROUND_EN to round half-up before the fractional shift (floor otherwise).
module color_correct_stencil
  import ccm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_b,
  input  logic             cfg_wen,
  input  logic [3:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata
);

  localparam coef_bank_t IDENT = ccm_identity(FRAC);

  logic             adv;
  logic             v1_q, v2_q, v3_q;
  logic [WIDTH-1:0] coef_q [NUM_COEF];
  logic [WIDTH-1:0] ch_out [3];

  // Every stage moves in lockstep; a stalled output freezes the whole pipe.
  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv && !rst;
  assign out_valid = v3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // S1 samples coef_q before this edge's write lands, so same-cycle pixels see old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_COEF); i++) begin
        coef_q[i] <= IDENT[i][WIDTH-1:0];
      end
    end else if (cfg_wen && (cfg_addr < 4'(NUM_COEF))) begin
      coef_q[cfg_addr] <= cfg_wdata;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    ccm_channel #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv),
      .r_i   (in_r),
      .g_i   (in_g),
      .b_i   (in_b),
      .m0_i  (coef_q[3*c]),
      .m1_i  (coef_q[3*c+1]),
      .m2_i  (coef_q[3*c+2]),
      .off_i (coef_q[9+c]),
      .out_o (ch_out[c])
    );
  end

  assign out_r = ch_out[0];
  assign out_g = ch_out[1];
  assign out_b = ch_out[2];

endmodule

// File: tb/tb_color_correct_stencil.sv
// Randomised self-checking bench for color_correct_stencil against an arithmetic reference.
// Honours CCM_ROUND_EN the same way as the design build.
module tb_color_correct_stencil;

  localparam int F = 8;

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] g;
    logic signed [31:0] b;
  } px_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, cfg_wen;
  logic [15:0] in_r, in_g, in_b, out_r, out_g, out_b, cfg_wdata;
  logic [3:0]  cfg_addr;

  int     checks = 0;
  int     failures = 0;
  longint mc [12];
  px_t    exp_q [$];
  px_t    got_q [$];

  logic acc, ov, ir;
  px_t  o;

  always #5 clk = ~clk;

  color_correct_stencil #(
    .WIDTH (16),
    .FRAC  (F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .cfg_wen   (cfg_wen),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  function automatic logic signed [31:0] s16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic px_t mkpx(input int r, input int g, input int b);
    return '{r: 32'(r), g: 32'(g), b: 32'(b)};
  endfunction

  function automatic void model_identity();
    for (int i = 0; i < 12; i++) mc[i] = 0;
    mc[0] = 256;
    mc[4] = 256;
    mc[8] = 256;
  endfunction

  // Real-valued matrix product scaled by 2^F, then floor (or round-half-up) and clamp.
  function automatic logic signed [31:0] ref_ch(input int c, input px_t p);
    longint den, num, q;
    den = longint'(1) << F;
    num = mc[3*c] * longint'(p.r) + mc[3*c+1] * longint'(p.g) + mc[3*c+2] * longint'(p.b)
          + mc[9+c] * den;
`ifdef CCM_ROUND_EN
    num = num + den / 2;
`endif
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 32'(q);
  endfunction

  task automatic step(input logic v, input px_t p, input logic ordy, input logic wen,
                      input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    in_valid  = v;
    in_r      = p.r[15:0];
    in_g      = p.g[15:0];
    in_b      = p.b[15:0];
    out_ready = ordy;
    cfg_wen   = wen;
    cfg_addr  = a;
    cfg_wdata = d;
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    ir  = in_ready;
    o   = '{r: s16(out_r), g: s16(out_g), b: s16(out_b)};
    if (out_valid && out_ready) got_q.push_back(o);
    if (acc) exp_q.push_back('{r: ref_ch(0, p), g: ref_ch(1, p), b: ref_ch(2, p)});
    if (wen && a < 4'd12) mc[a] = longint'(s16(d));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b1, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_wen = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; in_r = '0; in_g = '0; in_b = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out_r, out_g, out_b} !== 48'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b rgb=%h exp valid=0 rgb=0", out_valid,
               {out_r, out_g, out_b});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
    end
    model_identity();
    clear_sb();
  endtask

  task automatic test_identity();
    px_t pix [2];
    pix[0] = mkpx(100, 200, 300);
    pix[1] = mkpx(-5, 0, 7);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, pix[i], 1'b1, 1'b0, 4'd0, 16'd0);
      checks++;
      if (acc !== 1'b1) begin
        failures++;
        $display("FAIL ident_accept got=%b exp=1", acc);
      end
      for (int k = 1; k <= 3; k++) begin
        idle(1);
        checks++;
        if (ov !== (k == 3)) begin
          failures++;
          $display("FAIL ident_latency cycle=%0d got valid=%b exp=%b", k, ov, k == 3);
        end else if (k == 3 && o !== pix[i]) begin
          failures++;
          $display("FAIL ident_value got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", o.r, o.g, o.b,
                   pix[i].r, pix[i].g, pix[i].b);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_saturation();
    step(1'b0, '0, 1'b1, 1'b1, 4'd0, 16'h7FFF);
    step(1'b1, mkpx(32767, 0, 0), 1'b1, 1'b0, 4'd0, 16'd0);
    step(1'b1, mkpx(-32768, 0, 0), 1'b1, 1'b0, 4'd0, 16'd0);
    idle(6);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].r !== 32'sd32767 || got_q[1].r !== -32'sd32768) begin
        failures++;
        $display("FAIL sat_value got=(%0d,%0d) exp=(32767,-32768)", got_q[0].r, got_q[1].r);
      end
      checks++;
      if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
        failures++;
        $display("FAIL sat_model got_g=%0d got_b=%0d exp_g=%0d exp_b=%0d", got_q[0].g,
                 got_q[0].b, exp_q[0].g, exp_q[0].b);
      end
    end
    clear_sb();
  endtask

  task automatic test_rounding();
    int want_pos, want_neg;
`ifdef CCM_ROUND_EN
    want_pos = 5; want_neg = -4;
`else
    want_pos = 4; want_neg = -5;
`endif
    step(1'b0, '0, 1'b1, 1'b1, 4'd0, 16'h0180);
    step(1'b1, mkpx(3, 0, 0), 1'b1, 1'b0, 4'd0, 16'd0);
    step(1'b1, mkpx(-3, 0, 0), 1'b1, 1'b0, 4'd0, 16'd0);
    idle(6);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL round_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].r !== 32'(want_pos) || got_q[1].r !== 32'(want_neg)) begin
        failures++;
        $display("FAIL round_value got=(%0d,%0d) exp=(%0d,%0d)", got_q[0].r, got_q[1].r,
                 want_pos, want_neg);
      end
    end
    clear_sb();
  endtask

  task automatic test_config_race();
    step(1'b1, mkpx(0, 10, 0), 1'b1, 1'b1, 4'd4, 16'h0200);
    step(1'b1, mkpx(0, 10, 0), 1'b1, 1'b0, 4'd0, 16'd0);
    idle(6);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL race_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].g !== 32'sd10 || got_q[1].g !== 32'sd20) begin
        failures++;
        $display("FAIL race_value got=(%0d,%0d) exp=(10,20)", got_q[0].g, got_q[1].g);
      end
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    px_t  pix [10];
    int   idx;
    logic ordy, blk_prev;
    px_t  prev_o;
    idx = 0;
    blk_prev = 1'b0;
    prev_o = '0;
    for (int i = 0; i < 10; i++) pix[i] = '{r: s16(16'($urandom)), g: s16(16'($urandom)),
                                            b: s16(16'($urandom))};
    for (int t = 0; t < 30; t++) begin
      ordy = !(t >= 4 && t < 9);
      step(idx < 10, (idx < 10) ? pix[idx] : '0, ordy, 1'b0, 4'd0, 16'd0);
      if (acc) idx++;
      if (!ordy && ov) begin
        checks++;
        if (ir !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready t=%0d got=%b exp=0", t, ir);
        end
      end
      if (blk_prev) begin
        checks++;
        if (ov !== 1'b1 || o !== prev_o) begin
          failures++;
          $display("FAIL bp_stable t=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", t, o.r, o.g,
                   o.b, prev_o.r, prev_o.g, prev_o.b);
        end
      end
      blk_prev = ov && !ordy;
      prev_o = o;
    end
    checks++;
    if (got_q.size() != 10 || exp_q.size() != 10) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_order idx=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, got_q[i].r,
                 got_q[i].g, got_q[i].b, exp_q[i].r, exp_q[i].g, exp_q[i].b);
      end
    end
    clear_sb();
  endtask

  task automatic test_reset_midstream();
    step(1'b0, '0, 1'b1, 1'b1, 4'd0, 16'h0300);
    step(1'b1, mkpx(40, 50, 60), 1'b1, 1'b0, 4'd0, 16'd0);
    step(1'b1, mkpx(70, 80, 90), 1'b1, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valid got=%b exp=0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_identity();
    clear_sb();
    idle(5);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_stale got=%0d outputs exp=0", got_q.size());
    end
    step(1'b1, mkpx(7, -8, 9), 1'b1, 1'b0, 4'd0, 16'd0);
    idle(5);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== mkpx(7, -8, 9)) begin
      failures++;
      $display("FAIL midrst_identity got_count=%0d exp=(7,-8,9)", got_q.size());
    end
    clear_sb();
  endtask

  task automatic test_random();
    logic       wen;
    logic [3:0] a;
    logic [15:0] d;
    px_t        p;
    for (int t = 0; t < 300; t++) begin
      wen = ($urandom_range(0, 5) == 0);
      a   = 4'($urandom_range(0, 15));
      d   = (a >= 4'd9) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      p   = '{r: s16(16'($urandom)), g: s16(16'($urandom)), b: s16(16'($urandom))};
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) != 0, wen, a, d);
    end
    idle(8);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_value idx=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, got_q[i].r,
                 got_q[i].g, got_q[i].b, exp_q[i].r, exp_q[i].g, exp_q[i].b);
      end
    end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_rounding();
    test_config_race();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
